// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 core and its debug helpers.
// Holds the dump-reader FSM encoding and the storage geometry defaults.
package mips32_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned MEMD_ADDR_W = 10;
  localparam int unsigned REG_ADDR_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_FINISH  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/mips32_dump_reader.sv
// Debug read-out engine: walks an address range of a synchronous-read array and
// streams each word over valid/ready, one word per three cycles at full rate.
module mips32_dump_reader
  import mips32_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = MEMD_ADDR_W,
  parameter int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              last_q, last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      oaddr_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    last_d  = last_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_d  = start_addr;
            rem_d   = count;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_ISSUE: begin
        state_d = abort ? S_FINISH : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_FINISH;
        end else begin
          data_d  = rd_data;
          oaddr_d = addr_q;
          last_d  = (rem_q == CNT_W'(1));
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Abort wins over a same-cycle handshake: the word is dropped.
        if (abort) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_FINISH;
        end else if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          rem_d   = rem_q - 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = (rem_q == CNT_W'(1)) ? S_FINISH : S_ISSUE;
        end
      end
      S_FINISH: begin
        last_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en     = (state_q == S_ISSUE);
  assign rd_addr   = addr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = oaddr_q;
  assign out_last  = last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);

endmodule

// File: tb/tb_mips32_dump_reader.sv
// Bench for mips32_dump_reader: a synchronous-read array model, randomised consumer
// and a reference list of expected words computed from the dumped range.
module tb_mips32_dump_reader;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int CW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [CW-1:0] count = '0;
  logic          abort = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] obs_data [$];
  logic [AW-1:0] obs_addr [$];
  logic          obs_last [$];
  int obs_first, obs_done, obs_done_cyc, obs_rd;
  bit obs_unstable, obs_abort_bad, obs_timeout, obs_busy_after;

  mips32_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // abort_word >= 0: abort while that word index is on offer; -2: abort with start.
  task automatic run_dump(input logic [AW-1:0] a, input logic [CW-1:0] n, input int ready_pct,
                          input int stall_until, input int abort_word, input bit noise);
    int cyc;
    int abort_cyc;
    bit aborted;
    bit stalled;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    logic pl;
    obs_data.delete(); obs_addr.delete(); obs_last.delete();
    obs_first = -1; obs_done = 0; obs_done_cyc = -1; obs_rd = 0;
    obs_unstable = 0; obs_abort_bad = 0; obs_timeout = 0; obs_busy_after = 1;
    cyc = 0; abort_cyc = -1; aborted = 0; stalled = 0; pd = '0; pa = '0; pl = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; count = n; out_ready = 1'b0;
    abort = (abort_word == -2);
    forever begin
      @(posedge clk); #1;
      cyc++;
      start = noise && busy && ($urandom_range(0, 3) == 0);
      if (noise) begin
        start_addr = AW'($urandom);
        count = CW'($urandom);
      end
      abort = 1'b0;
      if (abort_word >= 0 && !aborted && out_valid && obs_data.size() == abort_word) begin
        abort = 1'b1; aborted = 1; abort_cyc = cyc;
      end
      out_ready = (cyc < stall_until) ? 1'b0 : ($urandom_range(1, 100) <= ready_pct);
      @(negedge clk);
      if (rd_en) obs_rd++;
      if (out_valid && obs_first < 0) obs_first = cyc;
      if (out_valid && stalled && (out_data !== pd || out_addr !== pa || out_last !== pl))
        obs_unstable = 1;
      if (aborted && cyc == abort_cyc + 1 && (out_valid !== 1'b0 || done !== 1'b1))
        obs_abort_bad = 1;
      stalled = out_valid && !out_ready;
      pd = out_data; pa = out_addr; pl = out_last;
      if (out_valid && out_ready && !abort) begin
        obs_data.push_back(out_data); obs_addr.push_back(out_addr); obs_last.push_back(out_last);
      end
      if (done) begin
        obs_done++;
        if (obs_done_cyc < 0) obs_done_cyc = cyc;
      end
      if (obs_done_cyc >= 0 && cyc == obs_done_cyc + 1) begin
        obs_busy_after = busy;
        break;
      end
      if (cyc > 20000) begin
        obs_timeout = 1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    tests++;
    if ({rd_en, rd_addr, out_valid, out_data, out_addr, out_last, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rd_en=%b rd_addr=%0h valid=%b data=%0h busy=%b done=%b, required all 0",
               rd_en, rd_addr, out_valid, out_data, busy, done);
    end
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_basic;
    mem[38] = 32'd4; mem[39] = 32'd5;
    run_dump(10'd38, 11'd2, 100, 0, -1, 0);
    tests++;
    if (obs_timeout || obs_data.size() != 2) begin
      fails++; $display("FAIL basic_len: got %0d words (timeout=%b), required 2", obs_data.size(), obs_timeout);
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (obs_data[i] !== DW'(4 + i) || obs_addr[i] !== AW'(38 + i) || obs_last[i] !== (i == 1)) begin
          fails++;
          $display("FAIL basic_word%0d: got %0h@%0d last=%b, required %0h@%0d last=%b",
                   i, obs_data[i], obs_addr[i], obs_last[i], 4 + i, 38 + i, i == 1);
        end
      end
    end
    tests++;
    if (obs_first != 3) begin fails++; $display("FAIL basic_latency: got %0d, required 3", obs_first); end
    tests++;
    if (obs_done_cyc != 7 || obs_done != 1) begin
      fails++; $display("FAIL basic_done: got cycle %0d pulses %0d, required cycle 7 pulses 1", obs_done_cyc, obs_done);
    end
    tests++;
    if (obs_rd != 2 || obs_busy_after !== 1'b0) begin
      fails++; $display("FAIL basic_rd_busy: got rd=%0d busy=%b, required rd=2 busy=0", obs_rd, obs_busy_after);
    end
  endtask

  task automatic test_empty;
    run_dump(10'd100, 11'd0, 100, 0, -1, 0);
    tests++;
    if (obs_data.size() != 0 || obs_first >= 0 || obs_rd != 0) begin
      fails++; $display("FAIL empty_activity: got words=%0d valid_at=%0d rd=%0d, required none",
                        obs_data.size(), obs_first, obs_rd);
    end
    tests++;
    if (obs_done != 1 || obs_done_cyc < 1 || obs_done_cyc > 2) begin
      fails++; $display("FAIL empty_done: got pulses %0d at %0d, required one pulse within 2 cycles",
                        obs_done, obs_done_cyc);
    end
  endtask

  task automatic test_stall;
    int ea;
    run_dump(10'd200, 11'd3, 100, 13, -1, 0);
    tests++;
    if (obs_unstable || obs_rd != 3 || obs_done_cyc != 20) begin
      fails++; $display("FAIL stall_hold: got unstable=%b rd=%0d done_at=%0d, required 0/3/20",
                        obs_unstable, obs_rd, obs_done_cyc);
    end
    tests++;
    if (obs_data.size() != 3) begin
      fails++; $display("FAIL stall_len: got %0d words, required 3", obs_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        ea = (200 + i) % DEPTH;
        tests++;
        if (obs_data[i] !== mem[ea] || obs_addr[i] !== AW'(ea) || obs_last[i] !== (i == 2)) begin
          fails++; $display("FAIL stall_word%0d: got %0h@%0d, required %0h@%0d", i, obs_data[i],
                            obs_addr[i], mem[ea], ea);
        end
      end
    end
  endtask

  task automatic test_wrap;
    int ea;
    int n;
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? 2 : DEPTH + 6;
      run_dump(AW'(DEPTH - 1 - 2 * t), CW'(n), 100, 0, -1, 0);
      tests++;
      if (obs_timeout || obs_data.size() != n) begin
        fails++; $display("FAIL wrap%0d_len: got %0d words, required %0d", t, obs_data.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          ea = (DEPTH - 1 - 2 * t + i) % DEPTH;
          if (obs_data[i] !== mem[ea] || obs_addr[i] !== AW'(ea) || obs_last[i] !== (i == n - 1)) begin
            tests++; fails++;
            $display("FAIL wrap%0d_word%0d: got %0h@%0d, required %0h@%0d", t, i, obs_data[i],
                     obs_addr[i], mem[ea], ea);
            break;
          end
        end
      end
    end
  endtask

  task automatic test_abort;
    run_dump(10'd500, 11'd4, 100, 0, 1, 0);
    tests++;
    if (obs_data.size() != 1 || obs_data[0] !== mem[500] || obs_addr[0] !== AW'(500)) begin
      fails++; $display("FAIL abort_words: got %0d words, required only word 0 (%0h)",
                        obs_data.size(), mem[500]);
    end
    tests++;
    if (obs_abort_bad || obs_done != 1 || obs_busy_after !== 1'b0) begin
      fails++; $display("FAIL abort_finish: got bad=%b done_pulses=%0d busy=%b, required 0/1/0",
                        obs_abort_bad, obs_done, obs_busy_after);
    end
    run_dump(10'd7, 11'd3, 100, 0, -2, 0);
    tests++;
    if (obs_data.size() != 3 || obs_last[2] !== 1'b1 || obs_data[2] !== mem[9]) begin
      fails++; $display("FAIL start_abort_idle: got %0d words, required 3 with start taken", obs_data.size());
    end
  endtask

  task automatic test_random;
    int n;
    int aw;
    int a;
    int nexp;
    int ea;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 20);
      aw = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      run_dump(AW'(a), CW'(n), $urandom_range(30, 100), 0, aw, 1);
      nexp = (aw >= 0) ? aw : n;
      tests++;
      if (obs_timeout || obs_data.size() != nexp || obs_done != 1 || obs_unstable || obs_abort_bad) begin
        fails++;
        $display("FAIL rand%0d_shape: got words=%0d done=%0d unstable=%b abort_bad=%b timeout=%b, required words=%0d done=1",
                 it, obs_data.size(), obs_done, obs_unstable, obs_abort_bad, obs_timeout, nexp);
      end else begin
        for (int i = 0; i < nexp; i++) begin
          ea = (a + i) % DEPTH;
          if (obs_data[i] !== mem[ea] || obs_addr[i] !== AW'(ea) || obs_last[i] !== (i == n - 1)) begin
            tests++; fails++;
            $display("FAIL rand%0d_word%0d: got %0h@%0d last=%b, required %0h@%0d last=%b", it, i,
                     obs_data[i], obs_addr[i], obs_last[i], mem[ea], ea, i == n - 1);
            break;
          end
        end
      end
    end
  endtask

  task automatic test_async_reset;
    bit saw_done;
    saw_done = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 10'd5; count = 11'd4; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    tests++;
    if ({rd_en, out_valid, out_data, out_addr, out_last, busy, done} !== '0) begin
      fails++; $display("FAIL async_reset: got busy=%b done=%b valid=%b data=%0h, required all 0",
                        busy, done, out_valid, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    tests++;
    if (saw_done) begin
      fails++; $display("FAIL async_reset_quiet: got done/busy activity after reset, required none");
    end
    run_dump(10'd5, 11'd4, 100, 0, -1, 0);
    tests++;
    if (obs_data.size() != 4 || obs_data[0] !== mem[5] || obs_data[3] !== mem[8]) begin
      fails++; $display("FAIL async_reset_restart: got %0d words, required 4 from address 5", obs_data.size());
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    #3;
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_wrap();
    test_abort();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
